// File: rtl/beat_detector_if.sv
// Sample/beat bundle between the HPF-fed beat detector and its neighbours.
// master drives the sample strobe, slave is the detector.
interface beat_if #(
   parameter int Width = 10,
   parameter int IW    = 16
);
   logic                    en;
   logic signed [Width-1:0] x_in;
   logic                    beat;
   logic [IW-1:0]           ivl;
   logic                    ivl_valid;
   logic                    timeout;
   logic signed [Width-1:0] thr_out;

   modport master (
      output en, x_in,
      input  beat, ivl, ivl_valid, timeout, thr_out
   );

   modport slave (
      input  en, x_in,
      output beat, ivl, ivl_valid, timeout, thr_out
   );
endinterface

// File: rtl/beat_detector.sv
// Adaptive-threshold peak detector with refractory window and
// beat-to-beat interval / no-beat timeout reporting.
module beat_detector #(
   parameter int Width    = 10,
   parameter int IW       = 16,
   parameter int REFRACT  = 50,
   parameter int MAX_IVL  = 400,
   parameter int THR_INIT = 100,
   parameter int THR_MIN  = 20
) (
   input logic   clk,
   input logic   rst,
   beat_if.slave bus
);
   localparam int RW = (REFRACT > 1) ? $clog2(REFRACT) : 1;

   localparam logic signed [Width-1:0] THR_INIT_V = Width'(THR_INIT);
   localparam logic signed [Width-1:0] THR_MIN_V  = Width'(THR_MIN);
   localparam logic [IW-1:0]           MAX_IVL_V  = IW'(MAX_IVL);
   localparam logic [RW-1:0]           RCNT_INIT  = RW'(REFRACT - 1);

   typedef enum logic [1:0] {
      SEARCH,
      RISE,
      REFR
   } state_t;

   state_t                  state_q, state_d;
   logic signed [Width-1:0] pk_q, pk_d;
   logic signed [Width-1:0] thr_q, thr_d;
   logic [IW-1:0]           cnt_q, cnt_d;
   logic [RW-1:0]           rcnt_q, rcnt_d;
   logic                    have_prev_q, have_prev_d;
   logic [IW-1:0]           ivl_q, ivl_d;
   logic                    ivl_valid_q, ivl_valid_d;
   logic                    beat_q, beat_d;
   logic                    timeout_q, timeout_d;

   logic [IW-1:0]           cnt_inc;
   logic                    is_beat;
   logic signed [Width:0]   sum_w;
   logic signed [Width-1:0] avg;
   logic signed [Width-1:0] half;
   logic signed [Width-1:0] thr_beat;
   logic signed [Width-1:0] thr_to;

   // One extra bit keeps thr+pk from wrapping before the halving.
   assign sum_w    = {thr_q[Width-1], thr_q} + {pk_q[Width-1], pk_q};
   assign avg      = sum_w[Width:1];
   assign half     = {thr_q[Width-1], thr_q[Width-1:1]};
   assign thr_beat = (avg < THR_MIN_V) ? THR_MIN_V : avg;
   assign thr_to   = (half < THR_MIN_V) ? THR_MIN_V : half;
   assign cnt_inc  = cnt_q + IW'(1);
   assign is_beat  = (state_q == RISE) && (bus.x_in < pk_q);

   // Next-state: peak FSM, interval counter, threshold adaptation.
   always_comb begin
      state_d     = state_q;
      pk_d        = pk_q;
      thr_d       = thr_q;
      cnt_d       = cnt_q;
      rcnt_d      = rcnt_q;
      have_prev_d = have_prev_q;
      ivl_d       = ivl_q;
      ivl_valid_d = ivl_valid_q;
      beat_d      = 1'b0;
      timeout_d   = 1'b0;
      if (bus.en) begin
         cnt_d = cnt_inc;
         unique case (state_q)
            SEARCH: begin
               if (bus.x_in > thr_q) begin
                  state_d = RISE;
                  pk_d    = bus.x_in;
               end
            end
            RISE: begin
               if (!is_beat) begin
                  pk_d = bus.x_in;
               end else begin
                  thr_d   = thr_beat;
                  rcnt_d  = RCNT_INIT;
                  state_d = REFR;
               end
            end
            REFR: begin
               if (rcnt_q == '0) begin
                  state_d = SEARCH;
               end else begin
                  rcnt_d = rcnt_q - RW'(1);
               end
            end
            default: state_d = SEARCH;
         endcase
         // A beat on the timeout strobe takes priority.
         if (is_beat) begin
            beat_d      = 1'b1;
            ivl_d       = cnt_inc;
            ivl_valid_d = have_prev_q;
            cnt_d       = '0;
            have_prev_d = 1'b1;
         end else if (cnt_inc == MAX_IVL_V) begin
            timeout_d   = 1'b1;
            cnt_d       = '0;
            have_prev_d = 1'b0;
            thr_d       = thr_to;
         end
      end
   end

   // State and registered outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= SEARCH;
         pk_q        <= '0;
         thr_q       <= THR_INIT_V;
         cnt_q       <= '0;
         rcnt_q      <= '0;
         have_prev_q <= 1'b0;
         ivl_q       <= '0;
         ivl_valid_q <= 1'b0;
         beat_q      <= 1'b0;
         timeout_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         pk_q        <= pk_d;
         thr_q       <= thr_d;
         cnt_q       <= cnt_d;
         rcnt_q      <= rcnt_d;
         have_prev_q <= have_prev_d;
         ivl_q       <= ivl_d;
         ivl_valid_q <= ivl_valid_d;
         beat_q      <= beat_d;
         timeout_q   <= timeout_d;
      end
   end

   assign bus.beat      = beat_q;
   assign bus.ivl       = ivl_q;
   assign bus.ivl_valid = ivl_valid_q;
   assign bus.timeout   = timeout_q;
   assign bus.thr_out   = thr_q;
endmodule
